// File: rtl/postprocess_pkg.sv
// Shared image-pipeline definitions: frame geometry defaults and the
// drain FSM state encoding used by the write-back stage.
package postprocess_pkg;

  localparam int DEF_MAX_IMG_COLS = 540;
  localparam int DEF_CNT_IMG_COLS = 10;
  localparam int DEF_MAX_IMG_ROWS = 960;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drainState_t;

endpackage

// File: rtl/postprocess_line_bank.sv
// One line of pixel storage: single write port, asynchronous single read port.
// Contents are deliberately not reset.
module pp_line_bank #(
  parameter int DEPTH = 540,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/postprocess.sv
// Write-back stage: clamps core results to 8 bits, buffers them in two
// ping-pong line banks and streams completed lines to the memory controller.
module postprocess
  import postprocess_pkg::*;
#(
  parameter int MAX_IMG_COLS = DEF_MAX_IMG_COLS,
  parameter int CNT_IMG_COLS = DEF_CNT_IMG_COLS,
  parameter int MAX_IMG_ROWS = DEF_MAX_IMG_ROWS,
  parameter int RES_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [RES_W-1:0] result_i,
  input  logic                    result_valid_i,
  output logic                    core_stall_o,
  output logic [7:0]              wdata_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  output logic                    wlast_o,
  output logic                    write_done_o,
  output logic                    frame_done_o,
  output logic                    overflow_o
);

  localparam int LINE_W = (MAX_IMG_ROWS > 1) ? $clog2(MAX_IMG_ROWS) : 1;
  localparam logic [CNT_IMG_COLS-1:0] LAST_COL  = CNT_IMG_COLS'(MAX_IMG_COLS - 1);
  localparam logic [LINE_W-1:0]       LAST_LINE = LINE_W'(MAX_IMG_ROWS - 1);

  drainState_t             r_state, w_stateNext;
  logic [1:0]              r_full, w_fullNext;
  logic                    r_fillBank, r_drainBank, r_overflow;
  logic [CNT_IMG_COLS-1:0] r_cntWrCol, r_cntRdCol;
  logic [LINE_W-1:0]       r_cntLine;
  logic [7:0]              w_pixel;
  logic                    w_wrEn, w_fillLast, w_beat, w_lastBeat;
  logic [7:0]              w_rdData [2];

  // Negative results saturate to black, anything above 255 to white.
  always_comb begin
    if (result_i[RES_W-1])          w_pixel = 8'h00;
    else if (|result_i[RES_W-2:8])  w_pixel = 8'hFF;
    else                            w_pixel = result_i[7:0];
  end

  assign core_stall_o = r_full[r_fillBank];
  assign overflow_o   = r_overflow;
  assign w_wrEn       = result_valid_i && !r_full[r_fillBank];
  assign w_fillLast   = w_wrEn && (r_cntWrCol == LAST_COL);
  assign w_beat       = (r_state == ST_DRAIN) && wready_i;
  assign w_lastBeat   = w_beat && (r_cntRdCol == LAST_COL);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pp_line_bank #(
      .DEPTH (MAX_IMG_COLS),
      .AW    (CNT_IMG_COLS)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_wrEn && (r_fillBank == 1'(b))),
      .i_waddr (r_cntWrCol),
      .i_wdata (w_pixel),
      .i_raddr (r_cntRdCol),
      .o_rdata (w_rdData[b])
    );
  end

  // Fill completion and drain release touch different banks, so both may land together.
  always_comb begin
    w_fullNext = r_full;
    if (w_fillLast) w_fullNext[r_fillBank] = 1'b1;
    if (r_state == ST_DONE) w_fullNext[r_drainBank] = 1'b0;
  end

  always_comb begin
    w_stateNext  = r_state;
    wvalid_o     = 1'b0;
    wlast_o      = 1'b0;
    wdata_o      = 8'h00;
    write_done_o = 1'b0;
    frame_done_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_full[r_drainBank]) w_stateNext = ST_DRAIN;
      end
      ST_DRAIN: begin
        wvalid_o = 1'b1;
        wdata_o  = w_rdData[r_drainBank];
        wlast_o  = (r_cntRdCol == LAST_COL);
        if (w_lastBeat) w_stateNext = ST_DONE;
      end
      ST_DONE: begin
        write_done_o = 1'b1;
        frame_done_o = (r_cntLine == LAST_LINE);
        w_stateNext  = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_full      <= 2'b00;
      r_fillBank  <= 1'b0;
      r_drainBank <= 1'b0;
      r_cntWrCol  <= '0;
      r_cntRdCol  <= '0;
      r_cntLine   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_full  <= w_fullNext;
      if (result_valid_i && r_full[r_fillBank]) r_overflow <= 1'b1;
      if (w_wrEn) begin
        if (w_fillLast) begin
          r_cntWrCol <= '0;
          r_fillBank <= ~r_fillBank;
        end else begin
          r_cntWrCol <= r_cntWrCol + 1'b1;
        end
      end
      if (w_beat) begin
        if (w_lastBeat) r_cntRdCol <= '0;
        else            r_cntRdCol <= r_cntRdCol + 1'b1;
      end
      if (r_state == ST_DONE) begin
        r_drainBank <= ~r_drainBank;
        if (r_cntLine == LAST_LINE) r_cntLine <= '0;
        else                        r_cntLine <= r_cntLine + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_postprocess.sv
// Randomized bench for postprocess against a line-occupancy / pixel-queue
// reference model; MAX_IMG_ROWS is shrunk to 4 so frame pulses are reachable.
module tb_postprocess;

  localparam int COLS = 540;
  localparam int ROWS = 4;

  logic               clk;
  logic               rst;
  logic signed [15:0] result_i;
  logic               result_valid_i;
  logic               core_stall_o;
  logic [7:0]         wdata_o;
  logic               wvalid_o;
  logic               wready_i;
  logic               wlast_o;
  logic               write_done_o;
  logic               frame_done_o;
  logic               overflow_o;

  postprocess #(
    .MAX_IMG_COLS (COLS),
    .CNT_IMG_COLS (10),
    .MAX_IMG_ROWS (ROWS),
    .RES_W        (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .result_i       (result_i),
    .result_valid_i (result_valid_i),
    .core_stall_o   (core_stall_o),
    .wdata_o        (wdata_o),
    .wvalid_o       (wvalid_o),
    .wready_i       (wready_i),
    .wlast_o        (wlast_o),
    .write_done_o   (write_done_o),
    .frame_done_o   (frame_done_o),
    .overflow_o     (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int cyc;

  // Reference model: accepted pixels in order, plus line bookkeeping.
  int expQ[$];
  int wrCount;
  int completedLines;
  int drainedLines;
  int beatIdx;
  int lineCount;
  bit doneDue;
  bit ovModel;
  bit prevHold;
  int prevData;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic int clampRef(input int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int randVal();
    return int'($urandom_range(0, 1099)) - 300;
  endfunction

  task automatic resetModel();
    expQ.delete();
    wrCount        = 0;
    completedLines = 0;
    drainedLines   = 0;
    beatIdx        = 0;
    lineCount      = 0;
    doneDue        = 1'b0;
    ovModel        = 1'b0;
    prevHold       = 1'b0;
    prevData       = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {wvalid_o, wlast_o, write_done_o, frame_done_o,
                      core_stall_o, overflow_o, wdata_o}, 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst            = 1'b1;
    result_valid_i = 1'b0;
    result_i       = '0;
    wready_i       = 1'b0;
    #1;
    checkAllZero("rst_outputs");
    checkOutput("rst_full", dut.r_full, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    resetModel();
    #1;
    checkAllZero("rst_release_outputs");
    @(posedge clk);
    #1;
    checkAllZero("first_cycle_outputs");
  endtask

  // One clock of stimulus; outputs are sampled mid-cycle and checked against the model.
  task automatic applyStimulus(input bit v, input int val, input bit rdy);
    int pending;
    bit stallM;
    @(negedge clk);
    result_valid_i = v;
    result_i       = 16'(val);
    wready_i       = rdy;
    #1;
    cyc++;
    pending = completedLines - drainedLines;
    stallM  = (pending == 2);
    checkOutput("core_stall", core_stall_o, 32'(stallM));
    checkOutput("overflow", overflow_o, 32'(ovModel));
    checkOutput("write_done", write_done_o, 32'(doneDue));
    checkOutput("frame_done", frame_done_o, 32'(doneDue && (lineCount == ROWS - 1)));
    if (doneDue) begin
      drainedLines++;
      lineCount = (lineCount + 1) % ROWS;
      doneDue   = 1'b0;
    end
    if (prevHold) begin
      checkOutput("hold_wvalid", wvalid_o, 1);
      checkOutput("hold_wdata", wdata_o, prevData);
    end
    if (wvalid_o) begin
      if (pending == 0 || expQ.size() == 0) begin
        checkOutput("spurious_wvalid", wvalid_o, 0);
      end else begin
        checkOutput("wdata", wdata_o, expQ[0]);
        checkOutput("wlast", wlast_o, 32'(beatIdx == COLS - 1));
        if (rdy) begin
          void'(expQ.pop_front());
          beatIdx++;
          if (beatIdx == COLS) begin
            beatIdx = 0;
            doneDue = 1'b1;
          end
        end
      end
    end else begin
      checkOutput("idle_outputs", {wlast_o, wdata_o}, 0);
    end
    prevHold = wvalid_o && !rdy;
    prevData = wdata_o;
    if (v) begin
      if (stallM) begin
        ovModel = 1'b1;
      end else begin
        expQ.push_back(clampRef(val));
        wrCount++;
        if (wrCount == COLS) begin
          wrCount = 0;
          completedLines++;
        end
      end
    end
  endtask

  task automatic drainAll(input bit toggleReady);
    int g;
    g = 0;
    while ((expQ.size() != 0 || doneDue) && g < 4000) begin
      applyStimulus(1'b0, 0, toggleReady ? bit'(cyc % 2) : 1'b1);
      g++;
    end
    checkOutput("drain_timeout", expQ.size(), 0);
  endtask

  initial begin
    int sent;
    int guard;
    checks         = 0;
    failures       = 0;
    cyc            = 0;
    rst            = 1'b1;
    result_valid_i = 1'b0;
    result_i       = '0;
    wready_i       = 1'b0;
    resetModel();
    resetDut();

    $display("[TB] clamp line");
    for (int i = 0; i < COLS; i++) begin
      int v;
      v = (i == 0) ? -5 : (i == 1) ? 300 : (i == 2) ? 128 : randVal();
      applyStimulus(1'b1, v, 1'b1);
    end
    drainAll(1'b0);

    $display("[TB] ramp line");
    for (int i = 0; i < COLS; i++) applyStimulus(1'b1, i % 256, 1'b1);
    drainAll(1'b0);

    $display("[TB] backpressure, two lines");
    sent  = 0;
    guard = 0;
    while (sent < 2 * COLS && guard < 20000) begin
      bit v;
      v = ($urandom_range(0, 3) != 0) && ((completedLines - drainedLines) != 2);
      applyStimulus(v, randVal(), bit'(cyc % 2));
      if (v) sent++;
      guard++;
    end
    checkOutput("bp_fill_timeout", sent, 2 * COLS);
    drainAll(1'b1);

    $display("[TB] overflow");
    for (int i = 0; i < 2 * COLS + 1; i++) applyStimulus(1'b1, randVal(), 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("stall_after_1080", core_stall_o, 1);
    checkOutput("overflow_sticky", overflow_o, 1);
    drainAll(1'b0);
    checkOutput("overflow_after_drain", overflow_o, 1);

    $display("[TB] reset mid-drain");
    for (int i = 0; i < COLS; i++) applyStimulus(1'b1, randVal(), 1'b0);
    guard = 0;
    while (beatIdx < 200 && guard < 2000) begin
      applyStimulus(1'b0, 0, 1'b1);
      guard++;
    end
    checkOutput("beat200_timeout", beatIdx, 200);
    resetDut();
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 0, 1'b1);
    checkOutput("post_reset_full", dut.r_full, 0);

    $display("[TB] line after reset");
    for (int i = 0; i < COLS; i++) applyStimulus(1'b1, randVal(), 1'b1);
    drainAll(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/postprocess.md
POSTPROCESS -- requirements
Module: postprocess

Interface
REQ-001 SHALL have parameter MAX_IMG_COLS, default 540, pixels per output line.
REQ-002 SHALL have parameter CNT_IMG_COLS, default 10, column counter width.
REQ-003 SHALL have parameter MAX_IMG_ROWS, default 960, lines per frame.
REQ-004 SHALL have parameter RES_W, default 16, width of the signed core result.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: result_i  in  RES_W  signed filtered pixel from core; result_valid_i  in  1  result_i valid this cycle.
REQ-007 SHALL have port core_stall_o  out  1, meaning the fill bank is full and the core must hold result_valid_i low.
REQ-008 SHALL have ports: wdata_o  out  8  pixel to memory controller; wvalid_o  out  1  wdata_o valid; wready_i  in  1  memory controller accepts; wlast_o  out  1  last pixel of line.
REQ-009 SHALL have ports: write_done_o  out  1  one-cycle pulse per line drained; frame_done_o  out  1  one-cycle pulse per frame drained; overflow_o  out  1  sticky, result dropped.

Function
REQ-010 SHALL clamp result_i: <0 gives 0, >255 gives 255, otherwise low 8 bits.
REQ-011 SHALL hold two line banks (bank 0/1) of MAX_IMG_COLS bytes each (ping-pong), plus full[1:0], fill_bank and drain_bank.
REQ-012 SHALL, when result_valid_i=1 and full[fill_bank]=0, write the clamped pixel to bank[fill_bank][cnt_wr_col] and increment cnt_wr_col.
REQ-013 SHALL, on the write at cnt_wr_col==MAX_IMG_COLS-1, set full[fill_bank], wrap cnt_wr_col to 0 and toggle fill_bank in the same cycle.
REQ-014 SHALL drive core_stall_o = full[fill_bank], combinationally.
REQ-015 SHALL drop a result when result_valid_i=1 and full[fill_bank]=1, and set overflow_o until reset.
REQ-016 SHALL implement drain FSM states IDLE, DRAIN and DONE.
REQ-017 In IDLE, SHALL go to DRAIN next cycle when full[drain_bank]=1.
REQ-018 In DRAIN, SHALL assert wvalid_o=1 with wdata_o = bank[drain_bank][cnt_rd_col], and wlast_o=1 when cnt_rd_col==MAX_IMG_COLS-1.
REQ-019 SHALL hold wdata_o, wvalid_o and wlast_o stable while wvalid_o=1 and wready_i=0.
REQ-020 SHALL advance cnt_rd_col only on wvalid_o&&wready_i; on the last beat, SHALL wrap cnt_rd_col to 0 and go to DONE.
REQ-021 In DONE (exactly one cycle), SHALL assert write_done_o, clear full[drain_bank], toggle drain_bank, increment cnt_line, then go to IDLE.
REQ-022 SHALL assert frame_done_o together with write_done_o when cnt_line==MAX_IMG_ROWS-1, and wrap cnt_line to 0.
REQ-023 SHALL allow filling and draining concurrently; fill and drain always address different banks when both are active.
REQ-024 SHALL, when a fill completes (REQ-013) and a DONE clear happens in the same cycle, apply both updates; they target different full bits.
REQ-025 SHALL drive outputs to 0 outside DRAIN/DONE: wvalid_o, wlast_o, wdata_o, write_done_o, frame_done_o.

Reset
REQ-026 SHALL, on rst=1 (asynchronous), clear FSM to IDLE, full to 00, fill_bank, drain_bank, cnt_wr_col, cnt_rd_col, cnt_line and overflow_o; bank contents are not reset.
REQ-027 SHALL discard a line partially filled or partially drained when reset is asserted mid-operation; no write_done_o follows.
REQ-028 SHALL hold all outputs at 0 during reset and in the first cycle after reset release.

Structure
REQ-029 SHALL place the FSM state encoding and the MAX_IMG_COLS/CNT_IMG_COLS/MAX_IMG_ROWS defaults in the shared image-pipeline package.
REQ-030 SHALL contain one sub-module, pp_line_bank: a single-port-write, single-port-read MAX_IMG_COLS x 8 array, instantiated twice.

Verification
REQ-031 Bench SHALL cover clamp: result_i = -5, 300, 128 -> stored pixels 0, 255, 128.
REQ-032 Bench SHALL cover one line: 540 valid results 0..539 (mod 256), wready_i=1 -> 540 beats in order, wlast_o on beat 540, write_done_o one cycle later.
REQ-033 Bench SHALL cover backpressure: wready_i toggling 1/0 -> wdata_o stable while stalled, no beat lost or duplicated.
REQ-034 Bench SHALL cover overflow: wready_i=0, 1081 results -> core_stall_o=1 after result 1080, result 1081 dropped, overflow_o=1.
REQ-035 Bench SHALL cover frame: MAX_IMG_ROWS=4, 4 lines -> frame_done_o pulses coincide with the 4th write_done_o only.
REQ-036 Bench SHALL cover reset at beat 200 of DRAIN -> all outputs 0 and full=00, with no write_done_o.
